// File: rtl/eda_loader_pkg.sv
// Shared types and geometry for the image RAM loader.
// CFG_* macros default here when no global define header supplies them.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif

package eda_loader_pkg;

  localparam int unsigned M           = `CFG_M;
  localparam int unsigned N           = `CFG_N;
  localparam int unsigned PIXEL_WIDTH = `CFG_PIXEL_WIDTH;
  localparam int unsigned I_WIDTH     = `CFG_I_WIDTH;
  localparam int unsigned J_WIDTH     = `CFG_J_WIDTH;
  localparam int unsigned ADDR_WIDTH  = `CFG_ADDR_WIDTH;
  localparam int unsigned LAST_I      = M - 1;
  localparam int unsigned LAST_J      = N - 1;

  typedef enum logic [0:0] {LD_IDLE, LD_LOAD} ld_state_t;

endpackage

// File: rtl/eda_img_loader_if.sv
// Pixel stream handshake plus image RAM write port of the loader.
interface eda_img_loader_if;
  import eda_loader_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [PIXEL_WIDTH-1:0] s_data;
  logic                   s_last;
  logic                   write_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [PIXEL_WIDTH-1:0] pixel_in;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, write_en, wr_addr, pixel_in
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, write_en, wr_addr, pixel_in
  );

endinterface

// File: rtl/eda_skid_buf.sv
// Two-entry skid FIFO with a registered ready; flush empties it in one cycle.
module eda_skid_buf #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push      = in_valid & ready_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign in_ready  = ready_q;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (flush) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < 2'd2);
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/eda_img_loader.sv
// Raster-order pixel stream to image RAM write port, with frame framing checks.
// Optional EDA_LOADER_SKID_EN adds a 2-entry skid buffer on the stream input.
module eda_img_loader
  import eda_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  eda_img_loader_if.slave         bus,
  output logic                    busy,
  output logic                    load_done,
  output logic                    err_early,
  output logic                    err_late
);

  ld_state_t              state_q;
  logic [I_WIDTH-1:0]     i_q;
  logic [J_WIDTH-1:0]     j_q;
  logic                   write_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [PIXEL_WIDTH-1:0] pixel_in_q;
  logic                   load_done_q;
  logic                   err_early_q, err_late_q;

  logic                   in_valid;
  logic                   in_last;
  logic [PIXEL_WIDTH-1:0] in_data;
  logic                   take;
  logic                   is_final;
  logic                   loading;

  assign loading  = (state_q == LD_LOAD);
  assign is_final = (i_q == I_WIDTH'(LAST_I)) && (j_q == J_WIDTH'(LAST_J));
  assign take     = in_valid & loading & ~abort;

`ifdef EDA_LOADER_SKID_EN
  logic skid_ready;
  logic skid_flush;

  // Anything still buffered when the frame ends or aborts belongs to no frame.
  assign skid_flush  = abort | (take & (is_final | in_last));
  assign bus.s_ready = skid_ready & loading;

  eda_skid_buf #(
    .Width(PIXEL_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (skid_flush),
    .in_valid (bus.s_valid & loading & ~abort),
    .in_ready (skid_ready),
    .in_data  ({bus.s_last, bus.s_data}),
    .out_valid(in_valid),
    .out_ready(take),
    .out_data ({in_last, in_data})
  );
`else
  assign bus.s_ready = loading;
  assign in_valid    = bus.s_valid;
  assign in_last     = bus.s_last;
  assign in_data     = bus.s_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LD_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      write_en_q  <= 1'b0;
      wr_addr_q   <= '0;
      pixel_in_q  <= '0;
      load_done_q <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      write_en_q  <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        LD_IDLE: begin
          if (start && !abort) begin
            state_q     <= LD_LOAD;
            i_q         <= '0;
            j_q         <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (abort) begin
            state_q <= LD_IDLE;
          end else if (take) begin
            write_en_q <= 1'b1;
            wr_addr_q  <= {i_q, j_q};
            pixel_in_q <= in_data;
            if (is_final) begin
              // Counters stay at the last cell; the next start clears them.
              load_done_q <= 1'b1;
              state_q     <= LD_IDLE;
              if (!in_last) err_late_q <= 1'b1;
            end else begin
              if (in_last) begin
                err_early_q <= 1'b1;
                state_q     <= LD_IDLE;
              end
              if (j_q == J_WIDTH'(LAST_J)) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  assign bus.write_en = write_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.pixel_in = pixel_in_q;
  assign busy         = loading;
  assign load_done    = load_done_q;
  assign err_early    = err_early_q;
  assign err_late     = err_late_q;

endmodule

// File: tb/tb_eda_img_loader.sv
// Directed-plus-random bench for eda_img_loader against a frame-level reference model.
module tb_eda_img_loader;
  import eda_loader_pkg::*;

  localparam int TOTAL = M * N;
  localparam int EW    = 1 + ADDR_WIDTH + PIXEL_WIDTH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, load_done, err_early, err_late;

  eda_img_loader_if bus ();

  eda_img_loader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .load_done(load_done),
    .err_early(err_early),
    .err_late (err_late)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0]          obs_q [$];
  int                     done_cnt = 0;
  logic [PIXEL_WIDTH-1:0] frame_data [TOTAL];

  // Write-port monitor: every write, with the load_done seen alongside it.
  always @(negedge clk) begin
    if (reset_n && bus.write_en) obs_q.push_back({load_done, bus.wr_addr, bus.pixel_in});
    if (reset_n && load_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int w);
    return 32'(((w / N) << J_WIDTH) | (w % N));
  endfunction

  task automatic fill_data(input bit counting);
    for (int w = 0; w < TOTAL; w++) frame_data[w] = counting ? PIXEL_WIDTH'(w) : PIXEL_WIDTH'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("errl_cleared_by_start", 32'(err_late), 0);
    check("erre_cleared_by_start", 32'(err_early), 0);
  endtask

  // Offer beats until n are accepted; gap_mode 0 = dense, 1 = alternate, 2 = random.
  task automatic send_beats(input int n, input int last_at, input int gap_mode);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 500) begin
      @(negedge clk);
      case (gap_mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (cyc % 2 == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      bus.s_data = frame_data[k];
      bus.s_last = (k + 1 == last_at);
      #1;
      if (bus.s_valid && bus.s_ready) k++;
      cyc++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("beats_accepted", 32'(k), 32'(n));
  endtask

  task automatic check_writes(input int n_exp, input bit exp_done);
    check("write_count", 32'(obs_q.size()), 32'(n_exp));
    for (int w = 0; w < obs_q.size() && w < n_exp; w++) begin
      logic [EW-1:0] e;
      e = obs_q[w];
      check("wr_addr", 32'(e[PIXEL_WIDTH +: ADDR_WIDTH]), exp_addr(w));
      check("pixel_in", 32'(e[PIXEL_WIDTH-1:0]), 32'(frame_data[w]));
      check("done_with_write", 32'(e[EW-1]), 32'(exp_done && (w == TOTAL - 1)));
    end
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
  endtask

  // last_at: 1-based beat carrying s_last, 0 for none.
  task automatic run_frame(input int last_at, input int gap_mode, input bit counting);
    int  n_exp;
    bit  early, late;
    n_exp = (last_at > 0 && last_at < TOTAL) ? last_at : TOTAL;
    early = (last_at > 0 && last_at < TOTAL);
    late  = (last_at != TOTAL) && !early;
    fill_data(counting);
    pulse_start();
    obs_q.delete();
    done_cnt = 0;
    send_beats(n_exp, last_at, gap_mode);
    repeat (4) @(negedge clk);
    check_writes(n_exp, !early);
    check("err_early", 32'(err_early), 32'(early));
    check("err_late", 32'(err_late), 32'(late));
    check("busy_end", 32'(busy), 0);
    check("s_ready_end", 32'(bus.s_ready), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write_en"}, 32'(bus.write_en), 0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check({tag, "_pixel_in"}, 32'(bus.pixel_in), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_load_done"}, 32'(load_done), 0);
    check({tag, "_err_early"}, 32'(err_early), 0);
    check({tag, "_err_late"}, 32'(err_late), 0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 32'(bus.s_ready), 0);

    // 1: dense counting frame; 2: alternating valid
    run_frame(TOTAL, 0, 1'b1);
    run_frame(TOTAL, 1, 1'b1);
    // 3: early s_last on beat 5; 4: no s_last at all
    run_frame(5, 0, 1'b0);
    run_frame(0, 0, 1'b0);

    // 5: abort with start in the same cycle after 7 beats; beat 8 is discarded
    fill_data(1'b0);
    pulse_start();
    obs_q.delete();
    done_cnt = 0;
    send_beats(7, 0, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = frame_data[7];
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.s_valid = 1'b0;
    check_writes(7, 1'b0);
    check("abort_busy", 32'(busy), 0);
    check("abort_s_ready", 32'(bus.s_ready), 0);

    // 6: reset mid-frame after 9 beats, then a clean frame
    fill_data(1'b0);
    pulse_start();
    send_beats(9, 0, 0);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    check_all_zero("midreset_hold");
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(TOTAL, 2, 1'b0);

    // Random frames with random gaps and framing
    for (int f = 0; f < 6; f++) begin
      int la;
      case ($urandom_range(0, 2))
        0:       la = 0;
        1:       la = TOTAL;
        default: la = int'($urandom_range(1, TOTAL - 1));
      endcase
      run_frame(la, 2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
